imem_prefetch_buffer: RTL and testbench
=======================================

Name: imem_prefetch_buffer

Overview:
- Instruction-fetch front end between a variable-latency instruction memory and the pipelined core's IF stage.
- Issues sequential word fetches ahead of the core, queues returned instructions with their PCs, and presents them in order.
- On a taken branch or jump redirect, flushes queued words and discards stale in-flight responses.
- Presents 32'b0 (NOP bubble) when empty, so the core's stall path sees the same encoding it already injects.

Parameters:
DEPTH, 4, queue entries and the cap on total outstanding plus queued fetches (power of 2, >=2)
RESET_PC, 32'h0040_0000, first fetch address after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
redirect  in  1  core requests non-sequential fetch; one-cycle pulse
redirect_pc  in  32  target of redirect, word aligned
out_ready  in  1  core accepts head entry this cycle
out_valid  out  1  head entry valid
out_inst  out  32  head instruction; 32'b0 when !out_valid
out_pc  out  32  PC of head instruction; 32'b0 when !out_valid
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_ack  in  1  request accepted this cycle (transfer = imem_req & imem_ack)
imem_rvalid  in  1  response data valid; responses return in request order
imem_rdata  in  32  response instruction word

Behaviour:
- Reset (async, immediate):
  - queue empty, so out_valid=0, out_inst=0, out_pc=0.
  - fetch_addr=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, imem_req=0.
- imem_addr = fetch_addr.
- imem_req = !redirect & (count + outstanding < DEPTH). Request must stay stable until acked.
- Issue: on imem_req & imem_ack, fetch_addr += 4 (wraps modulo 2^32) and outstanding += 1.
- Response: on imem_rvalid, outstanding -= 1.
  - If drop_cnt != 0: discard the word and decrement drop_cnt.
  - Else: push {resp_pc, imem_rdata} and resp_pc += 4.
- Pop: on out_valid & out_ready, the head advances. Head is visible in the cycle after push (1-cycle latency; see the optional feature).
- Simultaneous push and pop: legal when full or empty. Count is unchanged when both happen on a non-empty queue.
- Overflow is impossible by construction. The credit rule guarantees space for every outstanding response.
- Redirect (highest priority):
  - Queue cleared; any push or pop in that cycle is ignored.
  - fetch_addr = resp_pc = redirect_pc.
  - drop_cnt = outstanding - imem_rvalid, counting the current-cycle response as dropped.
  - No issue in the redirect cycle. The next request, to redirect_pc, goes out in the following cycle.
- Back-to-back redirects: the later one wins, and drop_cnt is recomputed each time.
- imem_rvalid while outstanding==0: ignored, with no state change. Counters saturate at 0.
- Throughput: with a 1-cycle-latency memory that always acks and out_ready held high, one instruction per cycle is sustained after fill.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, a non-dropped imem_rvalid is forwarded combinationally to out_valid/out_inst/out_pc in the same cycle.
  - If out_ready is also high, the word is consumed and not written.
  - Otherwise it is pushed as normal.
  - Redirect in the same cycle suppresses the bypass (out_valid=0).
- Undefined: no combinational path from imem_* to out_*. Minimum response-to-output latency is 1 cycle.

Test Plan:
1. Reset, memory acks every cycle, rdata=addr^32'hFFFF_FFFF with 1-cycle latency, out_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, ...; out_pc follows the same sequence, one per cycle after fill, and out_inst matches.
2. out_ready=0 with DEPTH=4 -> exactly 4 requests issued; imem_req low thereafter; out_pc=0x00400000 held stable. Raise out_ready -> 4 entries drain in order, then fetching resumes at 0x00400010.
3. Memory latency 3 with 3 requests outstanding; pulse redirect with redirect_pc=0x00400100 -> next request addresses 0x00400100; the 3 stale responses are discarded; first out_pc=0x00400100.
4. Redirect in the same cycle as imem_rvalid and a pop -> queue empty next cycle, drop_cnt=outstanding-1, no stale word ever appears on out_*.
5. Assert reset mid-stream with 2 entries queued -> out_valid=0 and imem_req=0 immediately (asynchronous); after release, fetch restarts at 0x00400000.
6. With PREFETCH_BYPASS_EN and an empty queue, rvalid with rdata=32'h2408_0005 and out_ready=1 -> out_valid=1 and out_inst=32'h2408_0005 in the same cycle, and the queue stays empty. Without the macro, the word appears the next cycle.

Source files
------------

// File: rtl/imem_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : imem_prefetch_buffer
// Description : Sequential instruction prefetch queue between a variable-
//               latency instruction memory and the core's IF stage. Flushes on
//               redirect and discards stale in-flight responses.
//               Optional macro PREFETCH_BYPASS_EN forwards a response straight
//               to out_* when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_sum_w = c_cnt_w + 1;

    logic [31:0]        r_inst_mem [DEPTH];
    logic [31:0]        r_pc_mem   [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop_cnt;
    logic [31:0]        r_fetch_addr;
    logic [31:0]        r_resp_pc;

    logic [c_sum_w-1:0] w_credit_sum;
    logic               w_has_credit;
    logic               w_issue;
    logic               w_resp;
    logic               w_drop;
    logic               w_keep;
    logic               w_empty;
    logic               w_bypass;
    logic               w_bypass_take;
    logic               w_push;
    logic               w_pop;

    // Queued entries plus in-flight fetches never exceed DEPTH, so every
    // response that returns is guaranteed a free slot.
    assign w_credit_sum = c_sum_w'(r_count) + c_sum_w'(r_outstanding);
    assign w_has_credit = (w_credit_sum < c_sum_w'(DEPTH));

    assign imem_req  = !reset && !redirect && w_has_credit;
    assign imem_addr = r_fetch_addr;

    assign w_issue = imem_req && imem_ack;
    // A response with nothing outstanding is spurious and ignored outright.
    assign w_resp  = imem_rvalid && (r_outstanding != '0);
    assign w_drop  = w_resp && (r_drop_cnt != '0);
    assign w_keep  = w_resp && (r_drop_cnt == '0) && !redirect;
    assign w_empty = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass  = w_keep && w_empty;
    assign out_valid = !w_empty || w_bypass;
    assign out_inst  = !w_empty ? r_inst_mem[r_rd_ptr] :
                       (w_bypass ? imem_rdata : 32'b0);
    assign out_pc    = !w_empty ? r_pc_mem[r_rd_ptr] :
                       (w_bypass ? r_resp_pc : 32'b0);
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_inst  = !w_empty ? r_inst_mem[r_rd_ptr] : 32'b0;
    assign out_pc    = !w_empty ? r_pc_mem[r_rd_ptr]   : 32'b0;
`endif

    // A forwarded word the core takes immediately never enters the queue.
    assign w_bypass_take = w_bypass && out_ready;
    assign w_push        = w_keep && !w_bypass_take;
    assign w_pop         = !w_empty && out_ready && !redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fetch_addr  <= RESET_PC;
            r_resp_pc     <= RESET_PC;
        end else if (redirect) begin
            // The response arriving this cycle is already stale, so it is
            // retired here rather than counted into drop_cnt.
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - c_cnt_w'(w_resp);
            r_drop_cnt    <= r_outstanding - c_cnt_w'(w_resp);
            r_fetch_addr  <= redirect_pc;
            r_resp_pc     <= redirect_pc;
        end else begin
            if (w_issue) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            r_outstanding <= r_outstanding + c_cnt_w'(w_issue) - c_cnt_w'(w_resp);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
            end
            if (w_keep) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_prefetch_buffer
// Description : Directed self-checking bench for imem_prefetch_buffer with a
//               fixed-latency in-order memory model (rdata = ~addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    imem_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0040_0000)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    int          lat;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] xfer_log [$];
    bit          ovr_en;
    logic [31:0] ovr_data;
    int          first_cyc;
    logic [31:0] first_pc;
    logic [31:0] first_inst;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive the memory response for the current cycle (called at negedge).
    task automatic mem_drive();
        logic [31:0] a;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            a = mq_addr.pop_front();
            void'(mq_due.pop_front());
            imem_rvalid = 1'b1;
            imem_rdata  = ovr_en ? ovr_data : ~a;
            ovr_en      = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    // Record this cycle's transfer, then move to the next cycle's negedge.
    task automatic next_cycle();
        if (imem_req && imem_ack) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
            xfer_log.push_back(imem_addr);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        imem_ack    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        ovr_en      = 1'b0;
        ovr_data    = 32'h0;
        lat         = 1;
        mq_addr.delete();
        mq_due.delete();
        xfer_log.delete();
        @(negedge clock);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_inst", out_inst, 32'h0);
        check_val("rst_out_pc", out_pc, 32'h0);
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_imem_addr", imem_addr, 32'h0040_0000);
        @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic scan_first(input int n);
        first_cyc  = -1;
        first_pc   = 32'h0;
        first_inst = 32'h0;
        for (int k = 0; k < n; k++) begin
            #1;
            if (out_valid && first_cyc < 0) begin
                first_cyc  = cyc;
                first_pc   = out_pc;
                first_inst = out_inst;
            end
            next_cycle();
        end
    endtask

    initial begin
        logic [31:0] e;

        // 1: streaming, 1-cycle memory, out_ready high
        do_reset();
        lat = 1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_val("t1_addr", imem_addr, 32'h0040_0000 + 32'(4 * k));
            check_val("t1_req", 32'(imem_req), 32'd1);
            if (k >= 2 - BYP) begin
                e = 32'h0040_0000 + 32'(4 * (k - 2 + BYP));
                check_val("t1_valid", 32'(out_valid), 32'd1);
                check_val("t1_pc", out_pc, e);
                check_val("t1_inst", out_inst, ~e);
            end else begin
                check_val("t1_fill_valid", 32'(out_valid), 32'd0);
            end
            next_cycle();
        end

        // 2: backpressure fills the queue, then drains in order
        do_reset();
        lat = 1; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k >= 2) check_val("t2_hold_pc", out_pc, 32'h0040_0000);
            next_cycle();
        end
        #1;
        check_val("t2_req_count", 32'(xfer_log.size()), 32'd4);
        check_val("t2_req_low", 32'(imem_req), 32'd0);
        check_val("t2_hold_inst", out_inst, ~32'h0040_0000);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("t2_drain_valid", 32'(out_valid), 32'd1);
            check_val("t2_drain_pc", out_pc, 32'h0040_0000 + 32'(4 * k));
            next_cycle();
        end
        check_val("t2_resume_addr", xfer_log.size() > 4 ? xfer_log[4] : 32'hFFFF_FFFF, 32'h0040_0010);

        // 3: redirect with 3 fetches in flight on a 3-cycle memory
        do_reset();
        lat = 3; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            next_cycle();
        end
        redirect = 1'b1; redirect_pc = 32'h0040_0100;
        #1;
        check_val("t3_redir_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check_val("t3_new_addr", imem_addr, 32'h0040_0100);
        check_val("t3_new_req", 32'(imem_req), 32'd1);
        next_cycle();
        scan_first(8);
        check_val("t3_first_cyc", 32'(first_cyc), 32'(8 - BYP));
        check_val("t3_first_pc", first_pc, 32'h0040_0100);
        check_val("t3_first_inst", first_inst, ~32'h0040_0100);

        // 4: redirect coinciding with a response and a pop
        do_reset();
        lat = 2; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            next_cycle();
        end
        redirect = 1'b1; redirect_pc = 32'h0040_0200;
        #1;
        check_val("t4_redir_rvalid", 32'(imem_rvalid), 32'd1);
        check_val("t4_redir_valid", 32'(out_valid), BYP ? 32'd0 : 32'd1);
        next_cycle();
        redirect = 1'b0;
        #1;
        check_val("t4_flushed", 32'(out_valid), 32'd0);
        check_val("t4_new_addr", imem_addr, 32'h0040_0200);
        next_cycle();
        scan_first(6);
        check_val("t4_first_cyc", 32'(first_cyc), 32'(7 - BYP));
        check_val("t4_first_pc", first_pc, 32'h0040_0200);

        // 5: asynchronous reset mid-stream with 2 entries queued
        do_reset();
        lat = 1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            next_cycle();
        end
        #1;
        check_val("t5_pre_valid", 32'(out_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_val("t5_async_valid", 32'(out_valid), 32'd0);
        check_val("t5_async_req", 32'(imem_req), 32'd0);
        check_val("t5_async_pc", out_pc, 32'h0);
        do_reset();
        lat = 1; out_ready = 1'b1;
        #1;
        check_val("t5_restart_addr", imem_addr, 32'h0040_0000);
        next_cycle();
        #1;
        next_cycle();
        #1;
        check_val("t5_restart_pc", out_pc, 32'h0040_0000 + 32'(4 * BYP));

        // 6: single response into an empty queue, then a spurious rvalid
        do_reset();
        lat = 1; out_ready = 1'b1;
        ovr_en = 1'b1; ovr_data = 32'h2408_0005;
        #1;
        next_cycle();
        imem_ack = 1'b0;
        #1;
        check_val("t6_c1_valid", 32'(out_valid), 32'(BYP));
        check_val("t6_c1_inst", out_inst, BYP ? 32'h2408_0005 : 32'h0);
        check_val("t6_c1_pc", out_pc, BYP ? 32'h0040_0000 : 32'h0);
        next_cycle();
        #1;
        check_val("t6_c2_valid", 32'(out_valid), 32'(1 - BYP));
        check_val("t6_c2_inst", out_inst, BYP ? 32'h0 : 32'h2408_0005);
        next_cycle();
        #1;
        check_val("t6_c3_empty", 32'(out_valid), 32'd0);
        mq_addr.push_back(32'h1234_5678);
        mq_due.push_back(cyc + 1);
        next_cycle();
        #1;
        check_val("t6_spur_rvalid", 32'(imem_rvalid), 32'd1);
        check_val("t6_spur_valid", 32'(out_valid), 32'd0);
        next_cycle();
        imem_ack = 1'b1;
        #1;
        check_val("t6_spur_noq", 32'(out_valid), 32'd0);
        check_val("t6_next_addr", imem_addr, 32'h0040_0004);
        next_cycle();
        #1;
        check_val("t6_resp_pc", out_pc, BYP ? 32'h0040_0004 : 32'h0);
        next_cycle();
        #1;
        check_val("t6_resp_pc2", out_pc, BYP ? 32'h0040_0008 : 32'h0040_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
